// File: rtl/gate_bist.sv
// gate_bist: stimulus/response self-test engine for a 2-input gate; define GATE_BIST_ERRCNT_EN to build the error counter.
module gate_bist #(
  parameter int HOLD_CYCLES = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       truth,
  output logic             dut_a,
  output logic             dut_b,
  input  logic             dut_y,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [1:0]       fail_vec,
  output logic [CNT_W-1:0] err_cnt
);
  localparam int HW = $clog2(HOLD_CYCLES + 1);
  typedef enum logic [1:0] {IDLE, APPLY, SAMPLE, DONE} state_t;
  state_t state, state_n;
  logic [1:0] vec, vec_n;
  logic [HW-1:0] hold;
  logic [3:0] truth_q;
  logic first_fail, mismatch, hold_end;
  always_comb begin
    hold_end = hold == HW'(HOLD_CYCLES - 1);
    mismatch = state == SAMPLE && dut_y != truth_q[vec];
    state_n = state == IDLE   ? (start ? APPLY : IDLE) :
              state == APPLY  ? (hold_end ? SAMPLE : APPLY) :
              state == SAMPLE ? (vec == 2'd3 ? DONE : APPLY) : IDLE;
    vec_n = state == IDLE ? 2'd0 : state == SAMPLE ? vec + 2'd1 : vec;
  end
  assign busy = state != IDLE;
  assign done = state == DONE;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      vec <= '0;
      hold <= '0;
      truth_q <= '0;
      first_fail <= 1'b0;
      fail_vec <= '0;
      pass <= 1'b0;
      {dut_a, dut_b} <= 2'b00;
    end else begin
      state <= state_n;
      vec <= vec_n;
      hold <= state == APPLY && !hold_end ? hold + 1'b1 : '0;
      // register the vector ahead of the state so the gate inputs never glitch
      {dut_a, dut_b} <= state_n == APPLY || state_n == SAMPLE ? vec_n : 2'b00;
      if (state == IDLE && start) begin
        truth_q <= truth;
        first_fail <= 1'b0;
        fail_vec <= '0;
        pass <= 1'b0;
      end
      if (mismatch && !first_fail) begin
        first_fail <= 1'b1;
        fail_vec <= vec;
      end
      if (state == SAMPLE && vec == 2'd3) pass <= !(first_fail || mismatch);
    end
  end
`ifdef GATE_BIST_ERRCNT_EN
  always_ff @(posedge clk) begin
    if (rst) err_cnt <= '0;
    else if (state == IDLE && start) err_cnt <= '0;
    else if (mismatch && err_cnt != '1) err_cnt <= err_cnt + 1'b1;
  end
`else
  assign err_cnt = '0;
`endif
endmodule
